// File: rtl/pipe_ctrl_if.sv
// pipe_ctrl_if: request/response bundle between a pipeline and its stall/flush controller.
//
// Signals (master = pipeline side, slave = controller side):
//   pause_req   [STAGES]  master->slave  level; bit i sets stage i's sticky pause
//   unpause_req [STAGES]  master->slave  bit i clears stage i's sticky pause
//   flush_req   [STAGES]  master->slave  bit k flushes every stage younger than k
//   timer_load            master->slave  one-cycle pulse starting a timed global pause
//   timer_val   [CW]      master->slave  timed-pause length, sampled with timer_load
//   stall       [STAGES]  slave->master  stage i holds its contents this cycle
//   flush       [STAGES]  slave->master  stage i is invalidated this cycle
//   state       [2]       slave->master  00 RUN, 01 HOLD, 10 TIMED, 11 FLUSH
//
// Handshake: there is no valid/ready pair. Every request input is sampled on
// every rising clock edge, and every response is a registered level that is
// valid for the whole cycle following the edge that produced it.
interface pipe_ctrl_if #(
    parameter int STAGES = 5,
    parameter int CW     = 4
);
    logic [STAGES-1:0] pause_req;
    logic [STAGES-1:0] unpause_req;
    logic [STAGES-1:0] flush_req;
    logic              timer_load;
    logic [CW-1:0]     timer_val;
    logic [STAGES-1:0] stall;
    logic [STAGES-1:0] flush;
    logic [1:0]        state;

    modport master (
        output pause_req, unpause_req, flush_req, timer_load, timer_val,
        input  stall, flush, state
    );

    modport slave (
        input  pause_req, unpause_req, flush_req, timer_load, timer_val,
        output stall, flush, state
    );
endinterface

// File: rtl/pipe_ctrl.sv
// pipe_ctrl: pipeline stall/flush controller.
//
// Keeps a sticky pause bit per stage, a down-counter for timed global pauses
// and a one-cycle flush register. All outputs are decoded from those
// registers only, so no input reaches an output combinationally.
//
// Ports:
//   clk  clock, all state updates on the rising edge
//   rst  asynchronous active-low reset
//   bus  pipe_ctrl_if.slave (requests in; stall, flush, state out)
//
// Stage 0 is the youngest (fetch) stage, STAGES-1 the oldest.
module pipe_ctrl #(
    parameter int STAGES = 5,
    parameter int CW     = 4
) (
    input  logic       clk,
    input  logic       rst,
    pipe_ctrl_if.slave bus
);

    typedef enum logic [1:0] {
        ST_RUN   = 2'b00,
        ST_HOLD  = 2'b01,
        ST_TIMED = 2'b10,
        ST_FLUSH = 2'b11
    } state_e;

    logic [STAGES-1:0] held_q, held_d;
    logic [STAGES-1:0] flush_q, flush_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [STAGES-1:0] younger;     // stage i lies below the highest flush request
    logic [STAGES-1:0] stall_c;
    state_e            state_c;

    // younger[i] is set when some flush_req[k] with k>i is set, i.e. i<kmax.
    // flush_req[0] has no younger stage, so it never marks anything here.
    always_comb begin
        logic acc;
        acc     = 1'b0;
        younger = '0;
        for (int i = STAGES - 1; i >= 0; i--) begin
            younger[i] = acc;
            acc        = acc | bus.flush_req[i];
        end
    end

    // Flush beats unpause, unpause beats pause, otherwise the bit is sticky.
    always_comb begin
        held_d = held_q;
        for (int i = 0; i < STAGES; i++) begin
            if (younger[i])
                held_d[i] = 1'b0;
            else if (bus.unpause_req[i])
                held_d[i] = 1'b0;
            else if (bus.pause_req[i])
                held_d[i] = 1'b1;
        end
    end

    assign flush_d = younger;

    // Any flush bit, including bit 0, cancels the timed pause.
    always_comb begin
        cnt_d = cnt_q;
        if (|bus.flush_req)
            cnt_d = '0;
        else if (bus.timer_load)
            cnt_d = bus.timer_val;
        else if (cnt_q != '0)
            cnt_d = cnt_q - CW'(1);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            held_q  <= '0;
            flush_q <= '0;
            cnt_q   <= '0;
        end else begin
            held_q  <= held_d;
            flush_q <= flush_d;
            cnt_q   <= cnt_d;
        end
    end

    // An older held stage stalls every younger stage; a running timer stalls
    // all of them; a stage being flushed is never stalled.
    always_comb begin
        logic older;
        older   = 1'b0;
        stall_c = '0;
        for (int i = STAGES - 1; i >= 0; i--) begin
            older      = older | held_q[i];
            stall_c[i] = (older | (cnt_q != '0)) & ~flush_q[i];
        end
    end

    always_comb begin
        if (flush_q != '0)
            state_c = ST_FLUSH;
        else if (cnt_q != '0)
            state_c = ST_TIMED;
        else if (held_q != '0)
            state_c = ST_HOLD;
        else
            state_c = ST_RUN;
    end

    assign bus.stall = stall_c;
    assign bus.flush = flush_q;
    assign bus.state = state_c;

endmodule

// File: tb/tb_pipe_ctrl.sv
module tb_pipe_ctrl;
  localparam int S  = 5;
  localparam int CW = 4;
  localparam int W  = 2 * S + 2;

  logic clk;
  logic rst;

  pipe_ctrl_if #(.STAGES(S), .CW(CW)) bus_if ();

  pipe_ctrl #(.STAGES(S), .CW(CW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus_if)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // reference model state, kept as plain arrays and an integer counter
  bit m_held[S];
  bit m_flush[S];
  int m_cnt;

  logic [W-1:0] exp_q[$];
  int checks;
  int failures;

  task automatic model_reset();
    for (int i = 0; i < S; i++) begin
      m_held[i]  = 1'b0;
      m_flush[i] = 1'b0;
    end
    m_cnt = 0;
  endtask

  // Advance the model by one clock edge given the request vectors.
  task automatic model_step(input logic [S-1:0] p, input logic [S-1:0] u,
                            input logic [S-1:0] f, input logic tl,
                            input logic [CW-1:0] tv);
    int kmax;
    kmax = -1;
    for (int k = 0; k < S; k++)
      if (f[k]) kmax = k;
    for (int i = 0; i < S; i++) begin
      if (i < kmax)   m_held[i] = 1'b0;
      else if (u[i])  m_held[i] = 1'b0;
      else if (p[i])  m_held[i] = 1'b1;
      m_flush[i] = (i < kmax);
    end
    if (kmax >= 0)    m_cnt = 0;
    else if (tl)      m_cnt = int'(tv);
    else if (m_cnt > 0) m_cnt = m_cnt - 1;
  endtask

  function automatic logic [W-1:0] model_out();
    logic [S-1:0] st;
    logic [S-1:0] fl;
    logic [1:0]   sv;
    bit any_held;
    bit any_flush;
    any_held  = 1'b0;
    any_flush = 1'b0;
    for (int i = 0; i < S; i++) begin
      bit older_held;
      older_held = 1'b0;
      for (int j = i; j < S; j++)
        if (m_held[j]) older_held = 1'b1;
      fl[i] = m_flush[i];
      st[i] = (older_held || m_cnt > 0) && !m_flush[i];
      if (m_held[i])  any_held  = 1'b1;
      if (m_flush[i]) any_flush = 1'b1;
    end
    if (any_flush)      sv = 2'b11;
    else if (m_cnt > 0) sv = 2'b10;
    else if (any_held)  sv = 2'b01;
    else                sv = 2'b00;
    return {st, fl, sv};
  endfunction

  // driver: apply requests at the falling edge, record the expected response
  task automatic step(input logic [S-1:0] p, input logic [S-1:0] u,
                      input logic [S-1:0] f, input logic tl,
                      input logic [CW-1:0] tv);
    @(negedge clk);
    bus_if.pause_req   = p;
    bus_if.unpause_req = u;
    bus_if.flush_req   = f;
    bus_if.timer_load  = tl;
    bus_if.timer_val   = tv;
    model_step(p, u, f, tl, tv);
    exp_q.push_back(model_out());
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step('0, '0, '0, 1'b0, '0);
  endtask

  task automatic compare(input string name, input logic [W-1:0] exp);
    logic [W-1:0] act;
    act = {bus_if.stall, bus_if.flush, bus_if.state};
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got stall=%b flush=%b state=%b, expected stall=%b flush=%b state=%b",
               name, act[W-1 -: S], act[W-S-1 -: S], act[1:0],
               exp[W-1 -: S], exp[W-S-1 -: S], exp[1:0]);
    end
  endtask

  // monitor: every cycle the DUT presents a fresh response just after the edge
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (rst && exp_q.size() > 0) compare("cycle", exp_q.pop_front());
    end
  end

  initial begin
    checks   = 0;
    failures = 0;
    model_reset();
    rst = 1'b0;
    bus_if.pause_req   = '0;
    bus_if.unpause_req = '0;
    bus_if.flush_req   = '0;
    bus_if.timer_load  = 1'b0;
    bus_if.timer_val   = '0;
    #12;
    compare("reset_state", '0);
    @(negedge clk);
    rst = 1'b1;

    // pause stage 2, hold, release
    step(5'b00100, '0, '0, 1'b0, '0);
    idle(3);
    step('0, 5'b00100, '0, 1'b0, '0);
    idle(1);

    // flush below stage 3 while stages 1,2 are held
    step(5'b00110, '0, '0, 1'b0, '0);
    idle(1);
    step('0, '0, 5'b01000, 1'b0, '0);
    idle(2);

    // timed pause of 3, then a zero-length load
    step('0, '0, '0, 1'b1, 4'd3);
    idle(4);
    step('0, '0, '0, 1'b1, 4'd0);
    idle(2);

    // collisions: pause+unpause, flush+timer_load
    step(5'b00100, 5'b00100, '0, 1'b0, '0);
    idle(1);
    step('0, '0, 5'b10000, 1'b1, 4'd5);
    idle(3);

    // flush_req[0] only cancels the timer
    step('0, '0, '0, 1'b1, 4'd4);
    step('0, '0, 5'b00001, 1'b0, '0);
    idle(2);

    // timer over a held oldest stage
    step(5'b10000, '0, '0, 1'b0, '0);
    step('0, '0, '0, 1'b1, 4'd2);
    idle(3);
    step('0, 5'b10000, '0, 1'b0, '0);
    idle(1);

    // maximum timer value, no truncation
    step('0, '0, '0, 1'b1, 4'd15);
    idle(16);

    // asynchronous reset mid-count and mid-hold
    step(5'b10000, '0, '0, 1'b0, '0);
    step('0, '0, '0, 1'b1, 4'd6);
    idle(1);
    @(posedge clk);
    #3;
    rst = 1'b0;
    #1;
    compare("async_reset", '0);
    model_reset();
    @(negedge clk);
    rst = 1'b1;
    idle(4);

    // randomized traffic
    for (int n = 0; n < 400; n++) begin
      logic [S-1:0] p, u, f;
      logic tl;
      logic [CW-1:0] tv;
      p  = ($urandom_range(0, 3) == 0) ? S'($urandom) : '0;
      u  = ($urandom_range(0, 3) == 0) ? S'($urandom) : '0;
      f  = ($urandom_range(0, 9) == 0) ? S'($urandom) : '0;
      tl = ($urandom_range(0, 7) == 0);
      tv = CW'($urandom_range(0, (1 << CW) - 1));
      step(p, u, f, tl, tv);
    end
    idle(2);

    @(posedge clk);
    #3;
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL drain: got %0d pending responses, expected 0", exp_q.size());
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
